// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical memory port between an I-cache and a
// D-cache. A request is granted from IDLE, its address/op/wdata are captured,
// and the captured copy alone drives physical memory until pmem_resp.
//
// Handshake: a requester raises x_read/x_write and holds it (with stable
// intent) until x_resp. x_resp is a one-cycle pulse that is high in the same
// cycle pmem_resp arrives, with x_rdata valid in that cycle. On the memory
// side, pmem_read/pmem_write stay high until pmem_resp, and pmem_resp is
// only meaningful while a strobe is high.
module cache_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_read,
  input  logic [15:0]  i_address,
  output logic [127:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [15:0]  d_address,
  input  logic [127:0] d_wdata,
  output logic [127:0] d_rdata,
  output logic         d_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic         busy,
  output logic [1:0]   fsm_state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0]   state;
  logic [1:0]   state_next;
  logic         last_grant;
  logic [15:0]  lat_addr;
  logic [127:0] lat_wdata;
  logic         lat_write;

  logic         i_req;
  logic         d_req;
  logic         pick_d;
  logic         grant;
  logic         serve_i;
  logic         serve_d;

  // Arbitration: D wins a tie unless round-robin says I was passed over last.
  always_comb begin
    i_req  = i_read;
    d_req  = d_read | d_write;
    pick_d = d_req && (!i_req || !RR_EN || (last_grant == GRANT_I));
    grant  = (state == IDLE) && (i_req || d_req);
  end

  // Next-state: grant from IDLE, return to IDLE on the memory completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = pick_d ? SERVE_D : SERVE_I;
      SERVE_I: if (pmem_resp) state_next = IDLE;
      SERVE_D: if (pmem_resp) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Capture the granted request so later input changes cannot reach memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= GRANT_I;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_write  <= 1'b0;
    end else if (grant) begin
      last_grant <= pick_d;
      if (pick_d) begin
        lat_addr  <= d_address;
        lat_write <= d_write;
        lat_wdata <= d_write ? d_wdata : '0;
      end else begin
        lat_addr  <= i_address;
        lat_write <= 1'b0;
        lat_wdata <= '0;
      end
    end
  end

  // Outputs: memory side from captured values only, zero outside SERVE.
  always_comb begin
    serve_i      = (state == SERVE_I);
    serve_d      = (state == SERVE_D);
    busy         = serve_i | serve_d;
    fsm_state    = state;
    pmem_read    = busy & ~lat_write;
    pmem_write   = busy & lat_write;
    pmem_address = busy ? (lat_addr & 16'hFFF0) : 16'h0000;
    pmem_wdata   = busy ? lat_wdata : '0;
    i_resp       = serve_i & pmem_resp;
    d_resp       = serve_d & pmem_resp;
    i_rdata      = serve_i ? pmem_rdata : '0;
    d_rdata      = serve_d ? pmem_rdata : '0;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: table-driven vectors against a round-robin instance plus
// hand-written sequences for write capture, reset abort and fixed priority.
module tb_cache_arbiter;

  localparam logic [127:0] PAT_A5 = {16{8'hA5}};
  localparam logic [127:0] PAT_5A = {16{8'h5A}};
  localparam logic [127:0] PAT_DB = {4{32'hDEADBEEF}};

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         i_read = 1'b0;
  logic [15:0]  i_address = '0;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [15:0]  d_address = '0;
  logic [127:0] d_wdata = '0;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  logic [127:0] i_rdata, d_rdata, pmem_wdata;
  logic         i_resp, d_resp, pmem_read, pmem_write, busy;
  logic [15:0]  pmem_address;
  logic [1:0]   fsm_state;

  logic [127:0] f_i_rdata, f_d_rdata, f_pmem_wdata;
  logic         f_i_resp, f_d_resp, f_pmem_read, f_pmem_write, f_busy;
  logic [15:0]  f_pmem_address;
  logic [1:0]   f_fsm_state;

  int vec_count = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  cache_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .busy(busy), .fsm_state(fsm_state)
  );

  cache_arbiter #(.RR_EN(1'b0)) dut_f (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_rdata(f_i_rdata), .i_resp(f_i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(f_d_rdata), .d_resp(f_d_resp),
    .pmem_read(f_pmem_read), .pmem_write(f_pmem_write), .pmem_address(f_pmem_address),
    .pmem_wdata(f_pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .busy(f_busy), .fsm_state(f_fsm_state)
  );

  // Clock.
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         ir;
    logic [15:0]  ia;
    logic         dr;
    logic         dw;
    logic [15:0]  da;
    logic         pr;
    logic [127:0] rd;
    logic         e_busy;
    logic         e_pr;
    logic         e_pw;
    logic [15:0]  e_pa;
    logic         e_ir;
    logic         e_dr;
    logic [127:0] e_irdata;
    logic [127:0] e_drdata;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [15:0] act);
    logic [15:0] exp;
    if (exp_q.size() == 0) begin
      vec_count++;
      miscompares++;
      $display("FAIL %s: got %h expected nothing (queue empty)", name, act);
    end else begin
      exp = exp_q.pop_front();
      chk(name, {112'd0, act}, {112'd0, exp});
    end
  endtask

  task automatic clear_inputs();
    i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
    d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    //            rst  ir   ia        dr   dw   da        pr   rd      busy pr   pw   pa        ir   dr   irdata  drdata
    vecs[0]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,128'd0, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,128'd0, 128'd0};
    vecs[1]  = '{1'b0,1'b1,16'h1234,1'b0,1'b0,16'h0000,1'b0,128'd0, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,128'd0, 128'd0};
    vecs[2]  = '{1'b0,1'b1,16'h1234,1'b0,1'b0,16'h0000,1'b0,128'd0, 1'b1,1'b1,1'b0,16'h1230,1'b0,1'b0,128'd0, 128'd0};
    vecs[3]  = '{1'b0,1'b1,16'hFFFF,1'b0,1'b0,16'h0000,1'b0,128'd0, 1'b1,1'b1,1'b0,16'h1230,1'b0,1'b0,128'd0, 128'd0};
    vecs[4]  = '{1'b0,1'b1,16'h1234,1'b0,1'b0,16'h0000,1'b1,PAT_A5, 1'b1,1'b1,1'b0,16'h1230,1'b1,1'b0,PAT_A5, 128'd0};
    vecs[5]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,128'd0, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,128'd0, 128'd0};
    vecs[6]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b1,PAT_A5, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,128'd0, 128'd0};
    vecs[7]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,128'd0, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,128'd0, 128'd0};
    vecs[8]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,128'd0, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,128'd0, 128'd0};
    vecs[9]  = '{1'b0,1'b1,16'h1111,1'b1,1'b0,16'h2222,1'b0,128'd0, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,128'd0, 128'd0};
    vecs[10] = '{1'b0,1'b1,16'h1111,1'b1,1'b0,16'h2222,1'b0,128'd0, 1'b1,1'b1,1'b0,16'h2220,1'b0,1'b0,128'd0, 128'd0};
    vecs[11] = '{1'b0,1'b1,16'h1111,1'b1,1'b0,16'h2222,1'b1,PAT_5A, 1'b1,1'b1,1'b0,16'h2220,1'b0,1'b1,128'd0, PAT_5A};
    vecs[12] = '{1'b0,1'b1,16'h1111,1'b1,1'b0,16'h2222,1'b0,128'd0, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,128'd0, 128'd0};
    vecs[13] = '{1'b0,1'b1,16'h1111,1'b1,1'b0,16'h2222,1'b0,128'd0, 1'b1,1'b1,1'b0,16'h1110,1'b0,1'b0,128'd0, 128'd0};
    vecs[14] = '{1'b0,1'b1,16'h1111,1'b1,1'b0,16'h2222,1'b1,PAT_A5, 1'b1,1'b1,1'b0,16'h1110,1'b1,1'b0,PAT_A5, 128'd0};
    vecs[15] = '{1'b0,1'b1,16'h1111,1'b1,1'b0,16'h2222,1'b0,128'd0, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,128'd0, 128'd0};
    vecs[16] = '{1'b0,1'b1,16'h1111,1'b1,1'b0,16'h2222,1'b0,128'd0, 1'b1,1'b1,1'b0,16'h2220,1'b0,1'b0,128'd0, 128'd0};
    vecs[17] = '{1'b0,1'b1,16'h1111,1'b1,1'b0,16'h2222,1'b1,PAT_5A, 1'b1,1'b1,1'b0,16'h2220,1'b0,1'b1,128'd0, PAT_5A};
    vecs[18] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,128'd0, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,128'd0, 128'd0};

    do_reset();

    // Table: single I read, idle pmem_resp, round-robin ties.
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      reset = vecs[k].rst; i_read = vecs[k].ir; i_address = vecs[k].ia;
      d_read = vecs[k].dr; d_write = vecs[k].dw; d_address = vecs[k].da;
      pmem_resp = vecs[k].pr; pmem_rdata = vecs[k].rd;
      #1;
      chk($sformatf("v%0d busy", k), {127'd0, busy}, {127'd0, vecs[k].e_busy});
      chk($sformatf("v%0d pmem_read", k), {127'd0, pmem_read}, {127'd0, vecs[k].e_pr});
      chk($sformatf("v%0d pmem_write", k), {127'd0, pmem_write}, {127'd0, vecs[k].e_pw});
      chk($sformatf("v%0d pmem_address", k), {112'd0, pmem_address}, {112'd0, vecs[k].e_pa});
      chk($sformatf("v%0d i_resp", k), {127'd0, i_resp}, {127'd0, vecs[k].e_ir});
      chk($sformatf("v%0d d_resp", k), {127'd0, d_resp}, {127'd0, vecs[k].e_dr});
      chk($sformatf("v%0d i_rdata", k), i_rdata, vecs[k].e_irdata);
      chk($sformatf("v%0d d_rdata", k), d_rdata, vecs[k].e_drdata);
    end

    // Writeback with inputs changing mid-transaction; write beats read.
    do_reset();
    exp_q.push_back(16'h8000);
    @(negedge clk);
    d_write = 1'b1; d_read = 1'b1; d_address = 16'h8008; d_wdata = PAT_DB;
    #1;
    chk("wr idle pmem_write", {127'd0, pmem_write}, 128'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) begin d_address = 16'h0000; d_wdata = '0; end
      pmem_resp = (c == 2); pmem_rdata = PAT_5A;
      #1;
      chk($sformatf("wr%0d pmem_write", c), {127'd0, pmem_write}, 128'd1);
      chk($sformatf("wr%0d pmem_read", c), {127'd0, pmem_read}, 128'd0);
      if (c == 0) sb_check("wr0 pmem_address", pmem_address);
      else chk($sformatf("wr%0d pmem_address", c), {112'd0, pmem_address}, {112'd0, 16'h8000});
      chk($sformatf("wr%0d pmem_wdata", c), pmem_wdata, PAT_DB);
      chk($sformatf("wr%0d d_resp", c), {127'd0, d_resp}, {127'd0, (c == 2)});
    end
    @(negedge clk);
    clear_inputs();
    #1;
    chk("wr done pmem_wdata", pmem_wdata, 128'd0);
    chk("wr done busy", {127'd0, busy}, 128'd0);

    // Reset in SERVE_D aborts; held d_read is re-granted after release.
    do_reset();
    exp_q.push_back(16'h4440);
    exp_q.push_back(16'h4440);
    @(negedge clk);
    d_read = 1'b1; d_address = 16'h4444;
    #1;
    chk("rst idle busy", {127'd0, busy}, 128'd0);
    @(negedge clk);
    #1;
    chk("rst serve pmem_read", {127'd0, pmem_read}, 128'd1);
    sb_check("rst serve pmem_address", pmem_address);
    @(negedge clk);
    reset = 1'b1; pmem_resp = 1'b1; pmem_rdata = PAT_A5;
    #1;
    chk("rst abort pmem_read", {127'd0, pmem_read}, 128'd0);
    chk("rst abort d_resp", {127'd0, d_resp}, 128'd0);
    chk("rst abort busy", {127'd0, busy}, 128'd0);
    chk("rst abort d_rdata", d_rdata, 128'd0);
    chk("rst abort fsm_state", {126'd0, fsm_state}, 128'd0);
    @(negedge clk);
    reset = 1'b0; pmem_resp = 1'b0;
    #1;
    chk("rst release busy", {127'd0, busy}, 128'd0);
    @(negedge clk);
    #1;
    chk("rst regrant pmem_read", {127'd0, pmem_read}, 128'd1);
    sb_check("rst regrant pmem_address", pmem_address);
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    chk("rst regrant d_resp", {127'd0, d_resp}, 128'd1);
    @(negedge clk);
    clear_inputs();

    // Fixed priority: D wins every tie, I only once D drops.
    do_reset();
    for (int r = 0; r < 3; r++) exp_q.push_back(16'h7770);
    exp_q.push_back(16'h3330);
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (r == 0) begin
        i_read = 1'b1; i_address = 16'h3330; d_read = 1'b1; d_address = 16'h7770;
      end
      if (r == 3) d_read = 1'b0;
      #1;
      chk($sformatf("fix%0d idle busy", r), {127'd0, f_busy}, 128'd0);
      @(negedge clk);
      pmem_resp = 1'b1; pmem_rdata = PAT_A5;
      #1;
      sb_check($sformatf("fix%0d pmem_address", r), f_pmem_address);
      chk($sformatf("fix%0d pmem_read", r), {127'd0, f_pmem_read}, 128'd1);
      chk($sformatf("fix%0d d_resp", r), {127'd0, f_d_resp}, {127'd0, (r < 3)});
      chk($sformatf("fix%0d i_resp", r), {127'd0, f_i_resp}, {127'd0, (r == 3)});
    end
    @(negedge clk);
    clear_inputs();
    #1;
    chk("fix done busy", {127'd0, f_busy}, 128'd0);
    chk("scoreboard drained", exp_q.size(), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
